// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM between two burst requesters.
// Optional read watchdog enabled by defining BURST_RAM_ARB_TIMEOUT_EN.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_cmd,
    input  logic                      m0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
    input  logic [63:0]               m0_wr_data,
    input  logic [7:0]                m0_data_mask,
    output logic                      m0_ack,
    output logic [63:0]               m0_rd_data,
    output logic                      m0_rd_data_valid,
    input  logic                      m1_cmd,
    input  logic                      m1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
    input  logic [63:0]               m1_wr_data,
    input  logic [7:0]                m1_data_mask,
    output logic                      m1_ack,
    output logic [63:0]               m1_rd_data,
    output logic                      m1_rd_data_valid,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]               br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [63:0]               br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_busy,
    output logic                      timeout_err
);
    localparam int CW = $clog2(BURST_COUNT + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t          r_state, w_next_state;
    logic            r_owner, w_next_owner;
    logic            r_last_grant, w_next_last_grant;
    logic [CW-1:0]   r_beat_cnt, w_next_beat_cnt;
    logic            w_tmo_hit;
    logic            w_drive;
    logic            w_own_cmd;
    logic [DEPTH_BITWIDTH-1:0] w_own_addr;
    logic [63:0]     w_own_wr_data;
    logic [7:0]      w_own_mask;

    assign w_own_cmd     = r_owner ? m1_cmd       : m0_cmd;
    assign w_own_addr    = r_owner ? m1_addr      : m0_addr;
    assign w_own_wr_data = r_owner ? m1_wr_data   : m0_wr_data;
    assign w_own_mask    = r_owner ? m1_data_mask : m0_data_mask;

    // State, owner and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_last_grant <= w_next_last_grant;
            r_beat_cnt   <= w_next_beat_cnt;
        end
    end

    // Arbitration and burst sequencing
    always_comb begin
        w_next_state      = r_state;
        w_next_owner      = r_owner;
        w_next_last_grant = r_last_grant;
        w_next_beat_cnt   = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (!br_busy && (m0_cmd_en || m1_cmd_en)) begin
                    // On a tie the requester not served last time wins
                    w_next_owner      = (m0_cmd_en && m1_cmd_en) ? ~r_last_grant : m1_cmd_en;
                    w_next_last_grant = w_next_owner;
                    w_next_state      = S_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_own_cmd) begin
                    w_next_beat_cnt = CW'(1);
                    w_next_state    = S_WRITE;
                end else begin
                    w_next_beat_cnt = '0;
                    w_next_state    = S_READ;
                end
            end
            S_WRITE: begin
                w_next_beat_cnt = r_beat_cnt + CW'(1);
                if (r_beat_cnt == LAST_BEAT) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WRITE;
                end
            end
            S_READ: begin
                if (br_rd_data_valid) begin
                    w_next_beat_cnt = r_beat_cnt + CW'(1);
                    w_next_state    = (r_beat_cnt == LAST_BEAT) ? S_IDLE : S_READ;
                end else if (w_tmo_hit) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_READ;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_drive          = (r_state == S_ISSUE) || (r_state == S_WRITE);
    assign br_cmd_en        = (r_state == S_ISSUE);
    assign br_cmd           = w_drive ? w_own_cmd     : 1'b0;
    assign br_addr          = w_drive ? w_own_addr    : '0;
    assign br_wr_data       = w_drive ? w_own_wr_data : 64'd0;
    assign br_data_mask     = w_drive ? w_own_mask    : 8'd0;
    assign m0_ack           = (r_state == S_ISSUE) && !r_owner;
    assign m1_ack           = (r_state == S_ISSUE) && r_owner;
    assign m0_rd_data       = br_rd_data;
    assign m1_rd_data       = br_rd_data;
    assign m0_rd_data_valid = (r_state == S_READ) && !r_owner && br_rd_data_valid;
    assign m1_rd_data_valid = (r_state == S_READ) && r_owner && br_rd_data_valid;

`ifdef BURST_RAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout_err;

    // The issue cycle counts as the first cycle of the read wait
    assign w_tmo_hit = (r_state == S_READ) && !br_rd_data_valid &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Read watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= TW'(1);
            end else if (r_state == S_READ) begin
                r_tmo_cnt <= br_rd_data_valid ? '0 : (r_tmo_cnt + TW'(1));
            end else begin
                r_tmo_cnt <= r_tmo_cnt;
            end
            if (w_tmo_hit) begin
                r_timeout_err <= 1'b1;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_hit   = 1'b0 & (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

endmodule
